// File: rtl/fir_dec_sched.sv
// Sequencer for the time-multiplexed decimating FIR: owns the sample ring write pointer,
// the decimation phase, and the per-output MAC burst (RUN / DRAIN / DONE).
module fir_dec_sched #(
    parameter int unsigned N_TAPS  = 160,
    parameter int unsigned N_DEC   = 8,
    parameter int unsigned AW      = 8,
    parameter int unsigned MAC_LAT = 2
) (
    input  logic          clk_8x,
    input  logic          rst,
    input  logic          in_valid,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] coef_addr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          mac_last,
    output logic          acc_latch,
    output logic          busy,
    output logic          primed,
    output logic          overrun
);

    localparam int unsigned FW = $clog2(N_TAPS + 1);
    localparam int unsigned DW = (N_DEC > 1) ? $clog2(N_DEC) : 1;
    localparam int unsigned LW = $clog2(MAC_LAT + 2);

    localparam logic [AW-1:0] LastAddr  = AW'(N_TAPS - 1);
    localparam logic [AW-1:0] PenAddr   = AW'(N_TAPS - 2);
    localparam logic [FW-1:0] FillFull  = FW'(N_TAPS);
    localparam logic [FW-1:0] FillLast  = FW'(N_TAPS - 1);
    localparam logic [DW-1:0] DecLast   = DW'(N_DEC - 1);
    localparam logic [LW-1:0] DrainLast = LW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e        state;
    logic [AW-1:0] wr_ptr;
    logic [DW-1:0] dec_cnt;
    logic [FW-1:0] fill_cnt;
    logic [LW-1:0] drain_cnt;
    logic          primed_next;
    logic          trigger;

    assign wr_en   = in_valid;
    assign wr_addr = wr_ptr;

    // primed as it will be once the current write lands, so the priming write can trigger
    assign primed_next = primed | (fill_cnt == FillLast);
    assign trigger     = in_valid & (dec_cnt == DecLast) & primed_next;

    always_ff @(posedge clk_8x) begin
        if (rst) begin
            state     <= StIdle;
            wr_ptr    <= '0;
            dec_cnt   <= '0;
            fill_cnt  <= '0;
            drain_cnt <= '0;
            rd_addr   <= '0;
            coef_addr <= '0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            mac_last  <= 1'b0;
            acc_latch <= 1'b0;
            busy      <= 1'b0;
            primed    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (in_valid) begin
                wr_ptr  <= (wr_ptr == LastAddr) ? '0 : wr_ptr + 1'b1;
                dec_cnt <= (dec_cnt == DecLast) ? '0 : dec_cnt + 1'b1;
                if (fill_cnt != FillFull) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
                if (primed_next) begin
                    primed <= 1'b1;
                end
            end

            acc_latch <= 1'b0;
            if (trigger && state != StIdle) begin
                overrun <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (trigger) begin
                        state     <= StRun;
                        rd_addr   <= wr_ptr;
                        coef_addr <= '0;
                        mac_en    <= 1'b1;
                        mac_clr   <= 1'b1;
                        mac_last  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                StRun: begin
                    mac_clr <= 1'b0;
                    if (coef_addr == LastAddr) begin
                        mac_en   <= 1'b0;
                        mac_last <= 1'b0;
                        if (MAC_LAT > 0) begin
                            state     <= StDrain;
                            drain_cnt <= '0;
                        end else begin
                            state     <= StDone;
                            acc_latch <= 1'b1;
                        end
                    end else begin
                        // walk backwards through the ring, wrapping at N_TAPS rather than 2^AW
                        rd_addr   <= (rd_addr == '0) ? LastAddr : rd_addr - 1'b1;
                        coef_addr <= coef_addr + 1'b1;
                        mac_last  <= (coef_addr == PenAddr);
                    end
                end
                StDrain: begin
                    if (drain_cnt == DrainLast) begin
                        state     <= StDone;
                        acc_latch <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
